// File: rtl/booth_mul_iter_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// partial-product select codes and the Booth digit decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_POS2 = 3'd2,
    SEL_NEG1 = 3'd3,
    SEL_NEG2 = 3'd4
  } sel_t;

  // Map a Booth digit {q[2i+1], q[2i], q[2i-1]} to its partial-product select
  function automatic sel_t booth_decode(input logic [2:0] digit);
    case (digit)
      3'b001, 3'b010: return SEL_POS1;
      3'b011:         return SEL_POS2;
      3'b100:         return SEL_NEG2;
      3'b101, 3'b110: return SEL_NEG1;
      default:        return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_iter_if.sv
// Request/response bundle of the Booth multiplier: operand handshake,
// result handshake, flush and busy status.
interface booth_mul_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  // Requester side (pipeline / HI-LO control)
  modport master (
    output flush, in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, hi, lo, busy
  );

  // Multiplier side
  modport slave (
    input  flush, in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, hi, lo, busy
  );
endinterface

// File: rtl/booth_mul_iter_pp_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +M, +2M, -M or -2M
// (two's complement, modulo 2^WIDTH2) from a 3-bit Booth digit.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH2 = 64
) (
  input  logic [2:0]        digit,
  input  logic [WIDTH2-1:0] m,
  output logic [WIDTH2-1:0] pp
);

  sel_t              sel;
  logic [WIDTH2-1:0] m2;

  assign sel = booth_decode(digit);
  assign m2  = {m[WIDTH2-2:0], 1'b0};

  // Select the signed multiple of M for this digit
  always_comb begin
    pp = '0;
    case (sel)
      SEL_POS1: pp = m;
      SEL_POS2: pp = m2;
      SEL_NEG1: pp = -m;
      SEL_NEG2: pp = -m2;
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for the HI/LO path (MULT / MULTU).
// One Booth digit is retired per clock; N = (WIDTH+2)/2 digits per product.
// Optional feature macro: BOOTH_MUL_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits can only produce zero digits.
module booth_mul_iter
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  booth_mul_iter_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int QW = WIDTH + 2;
  localparam int N  = (WIDTH + 2) / 2;
  localparam int CW = $clog2(N + 1);

  state_t          state_reg, state_next;
  logic [W2-1:0]   m_reg;
  logic [W2-1:0]   acc_reg;
  logic [W2-1:0]   pp;
  logic [QW-1:0]   q_reg;
  logic [QW-1:0]   q_next;
  logic            qm1_reg;
  logic            qm1_next;
  logic [CW-1:0]   cnt_reg;
  logic            accept;
  logic            early_exit;
  logic            last_digit;
  logic            in_ready_c;
  logic            out_valid_c;
  logic            busy_c;

  // Flush wins over a new request arriving in the same cycle
  assign accept = bus.in_valid && (state_reg == ST_IDLE) && !bus.flush;

  // Arithmetic shift keeps the top bit so unconsumed digits stay consistent
  assign q_next   = {{2{q_reg[QW-1]}}, q_reg[QW-1:2]};
  assign qm1_next = q_reg[1];

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  logic [QW:0] rest_bits;
  assign rest_bits  = {q_next, qm1_next};
  // All-equal remaining bits decode to zero digits only
  assign early_exit = (&rest_bits) | ~(|rest_bits);
`else
  assign early_exit = 1'b0;
`endif

  assign last_digit = (cnt_reg == CW'(N - 1)) || early_exit;

  booth_pp_sel #(
    .WIDTH2 (W2)
  ) u_pp_sel (
    .digit (q_reg[1:0] == 2'b00 && !qm1_reg ? 3'b000 : {q_reg[1:0], qm1_reg}),
    .m     (m_reg),
    .pp    (pp)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: flush > accept / iterate / drain
  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.in_valid)  state_next = ST_BUSY;
        ST_BUSY: if (last_digit)    state_next = ST_DONE;
        ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_reg)
      ST_IDLE: in_ready_c = 1'b1;
      ST_BUSY: busy_c = 1'b1;
      ST_DONE: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
      end
      default: in_ready_c = 1'b0;
    endcase
  end

  // Operand capture and one Booth digit of accumulation per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      q_reg   <= '0;
      qm1_reg <= 1'b0;
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (bus.flush) begin
      cnt_reg <= '0;
    end else if (accept) begin
      m_reg   <= {{WIDTH{bus.a[WIDTH-1] & bus.is_signed}}, bus.a};
      q_reg   <= {{2{bus.b[WIDTH-1] & bus.is_signed}}, bus.b};
      qm1_reg <= 1'b0;
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (state_reg == ST_BUSY) begin
      acc_reg <= acc_reg + pp;
      m_reg   <= {m_reg[W2-3:0], 2'b00};
      q_reg   <= q_next;
      qm1_reg <= qm1_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.hi        = acc_reg[W2-1:WIDTH];
  assign bus.lo        = acc_reg[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter (WIDTH=32): randomized and directed
// multiplies checked by a scoreboard against a plain-arithmetic model.
// Works with or without BOOTH_MUL_EARLY_EXIT_EN defined.
module tb_booth_mul_iter;

  localparam int W = 32;
  localparam int N = (W + 2) / 2;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_cyc;
    int             lat;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         flush_d;
  logic         in_valid_d;
  logic         is_signed_d;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;
  int           mode;     // 0: out_ready=1, 1: random, 2: out_ready=0
  logic         rnd_bit;
  int           cyc;
  int           checks;
  int           errors;
  int           txn;
  exp_t         sb[$];

  booth_mul_iter_if #(.WIDTH(W)) bus ();

  booth_mul_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.flush     = flush_d;
  assign bus.in_valid  = in_valid_d;
  assign bus.is_signed = is_signed_d;
  assign bus.a         = a_d;
  assign bus.b         = b_d;
  assign bus.out_ready = (mode == 0) || (mode == 1 && rnd_bit);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Mathematical product modulo 2^(2W)
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
    logic [2*W-1:0] pa, pb;
    pa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    pb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return pa * pb;
  endfunction

  // Cycles until the remaining multiplier bits are all equal (or N without early exit)
  function automatic int model_lat(input logic [W-1:0] b, input logic s);
    logic [W+2:0] v;
    bit           same;
    if (!EE) return N;
    v = {s & b[W-1], s & b[W-1], b, 1'b0};
    for (int k = 1; k <= N; k++) begin
      same = 1'b1;
      for (int j = 2 * k; j <= W + 2; j++) if (v[j] != v[W+2]) same = 1'b0;
      if (same) return k;
    end
    return N;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    in_valid_d  = 1'b1;
    a_d         = a;
    b_d         = b;
    is_signed_d = s;
    @(posedge clk);
    #1;
    in_valid_d  = 1'b0;
    e.prod      = model_prod(a, b, s);
    e.acc_cyc   = cyc;
    e.lat       = model_lat(b, s);
    e.a         = a;
    e.b         = b;
    e.s         = s;
    sb.push_back(e);
    a_d = $urandom;
    b_d = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares every presented result against the scoreboard head
  initial begin
    logic           prev_valid;
    logic [2*W-1:0] prev_prod;
    exp_t           e;
    prev_valid = 1'b0;
    prev_prod  = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.out_valid) begin
        prev_valid = 1'b0;
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h required=none", {bus.hi, bus.lo});
        prev_valid = 1'b0;
      end else begin
        if (!prev_valid)
          chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
        else
          chk("hold", {bus.hi, bus.lo}, prev_prod);
        chk("busy_done", 64'(bus.busy), 64'd1);
        prev_valid = !bus.out_ready;
        prev_prod  = {bus.hi, bus.lo};
        if (bus.out_ready) begin
          e = sb.pop_front();
          chk("product", {bus.hi, bus.lo}, e.prod);
          txn++;
          $display("txn %0d s=%0d a=%h b=%h hi=%h lo=%h", txn, e.s, e.a, e.b, bus.hi, bus.lo);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    txn         = 0;
    mode        = 0;
    rst         = 1'b1;
    flush_d     = 1'b0;
    in_valid_d  = 1'b0;
    is_signed_d = 1'b0;
    a_d         = '0;
    b_d         = '0;

    // Reset values
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    do_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(32'd5, 32'd0, 1'b1);
    do_op(32'd5, 32'd3, 1'b1);
    do_op(32'd9, 32'hFFFF_FFFF, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    drain();

    // Randomized operands with random consumer backpressure
    sync();
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom_range(0, 15);
        1: rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        2: rb = $urandom & 32'h0000_FFFF;
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();

    // Held backpressure in DONE: result stable, requests ignored
    sync();
    mode = 2;
    do_op(32'd3, 32'd4, 1'b0);
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      in_valid_d = 1'b1;
      a_d = $urandom;
      b_d = $urandom;
      @(posedge clk);
      #1;
      in_valid_d = 1'b0;
    end
    mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    // Flush in the middle of an operation
    do_op(32'd7, 32'd7, 1'b0);
    repeat (7) sync();
    flush_d = 1'b1;
    sync();
    flush_d = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    repeat (25) @(negedge clk);
    do_op(32'd5, 32'd6, 1'b0);
    drain();

    // Asynchronous reset in the middle of an operation
    do_op(32'd123, 32'hFFFF_F000, 1'b1);
    repeat (5) sync();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    do_op(32'hFFFF_FFF0, 32'd16, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
